tensor_desc_loader: RTL
=======================

Name: tensor_desc_loader

Overview:
DMA-style writer that fills the tensor descriptor table from memory. It accepts a load command (memory base, first table index, count), fetches each 256-bit descriptor as BEAT_BITS-wide read beats, and assembles them. It writes each completed descriptor through the table's single-cycle write port (wr_en/wr_addr/wr_data). The block sits between the graph controller/host command path and the descriptor table, replacing bench-driven table loads.

Parameters:
NUM_ENTRIES, 256, number of table entries
ENTRY_BITS, 256, descriptor width in bits
ADDR_W, $clog2(NUM_ENTRIES), table index width
MEM_AW, 32, memory byte-address width
BEAT_BITS, 32, memory read data width; ENTRY_BITS must be a multiple of it
BEATS, ENTRY_BITS/BEAT_BITS, beats per descriptor (derived, localparam)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  load command valid
cmd_ready  out  1  high only in IDLE
cmd_mem_base  in  MEM_AW  byte address of first descriptor; must be BEAT_BITS/8-aligned
cmd_tbl_base  in  ADDR_W  first table index
cmd_count  in  ADDR_W+1  descriptors to load, 0..NUM_ENTRIES
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  MEM_AW  request byte address
mem_rsp_valid  in  1  read data valid (no backpressure)
mem_rsp_data  in  BEAT_BITS  read data
mem_rsp_err  in  1  response error, qualified by mem_rsp_valid
tbl_wr_en  out  1  table write strobe
tbl_wr_addr  out  ADDR_W  table write index
tbl_wr_data  out  ENTRY_BITS  assembled descriptor
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at command end (normal or error)
err  out  1  sticky error; cleared on next accepted command
xsum  out  BEAT_BITS  XOR checksum of all beats of the last command

Behaviour:
- Reset (async, rst_n low): state IDLE; cmd_ready=1; mem_req_valid=0; tbl_wr_en=0; tbl_wr_addr=0; tbl_wr_data=0; busy=0; done=0; err=0; xsum=0; all counters 0. Reset mid-command aborts it immediately with no further writes and no done pulse.
- FSM states:
  - IDLE: on cmd_valid&&cmd_ready, latch the command, clear err and xsum. Go to FINISH if count==0, else REQ.
  - REQ: mem_req_valid=1 with addr=cur_addr. On mem_req_ready, go to WAIT and advance cur_addr by BEAT_BITS/8. mem_req_addr and mem_req_valid are held stable until accepted.
  - WAIT: on mem_rsp_valid:
    - If mem_rsp_err: set err, go to FINISH.
    - Else store the beat at bits [beat_idx*BEAT_BITS +: BEAT_BITS] (beat 0 = LSBs, little-endian).
    - If beat_idx==BEATS-1, go to WRITE; else go to REQ and increment beat_idx.
  - WRITE: tbl_wr_en=1 for exactly one cycle with tbl_wr_addr=cur_idx and the assembled data. Then cur_idx+1 (wraps modulo NUM_ENTRIES, 255->0), remaining-1, beat_idx=0. Go to FINISH if remaining becomes 0, else REQ.
  - FINISH: done=1 for one cycle, go to IDLE.
- One request is outstanding at a time. A response arriving outside WAIT is ignored.
- Latency per descriptor with zero-wait memory (ready=1, response the cycle after acceptance): 2*BEATS+1 cycles. Command overhead: +1 accept cycle, +1 FINISH cycle.
- Memory address is never wrapped by the block; it is a plain MEM_AW-bit add.
- On error, the partially assembled descriptor is discarded and descriptors already written remain in the table.
- tbl_wr_data holds its last value when tbl_wr_en=0.
- Commands are not accepted while busy; cmd_valid may stay asserted.

Optional Feature:
DESC_LOADER_XSUM_EN
- Defined: xsum is XORed with every accepted non-error beat, cleared on command accept, and holds after done.
- Undefined: xsum is tied to 0 and no checksum logic is built.

Decomposition:
- graph_isa_pkg gains the loader FSM state enum (IDLE/REQ/WAIT/WRITE/FINISH) and a DESC_BYTES=32 constant.
- A sub-module desc_beat_packer (beat shift/insert register with beat index, clear, full flag) is natural. The top module holds the FSM and counters.

Test Plan:
- Reset mid-load: assert rst_n=0 during the 3rd descriptor of a count=5 load -> all outputs return to reset values and no tbl_wr_en after reset.
- Single load, zero-wait memory: cmd(base=0x100, tbl=3, count=1), memory returns word = byte address -> one write at index 3 with data {0x11C,...,0x100}; done 18 cycles after accept; exactly 8 requests at addresses 0x100..0x11C.
- Wrap: tbl=254, count=4 -> writes at 254, 255, 0, 1; mem addresses contiguous 0x0..0x7C; count=0 command -> done 1 cycle after accept, zero requests, zero writes.
- Backpressure: random mem_req_ready (~30%) and random 0-5 cycle response latency, count=16 -> table contents match the memory model; mem_req_addr is stable while valid&&!ready.
- Error: mem_rsp_err on beat 4 of descriptor 2 (count=3, tbl=10) -> entries 10 and 11 written, no write to 12, err=1, one done pulse; the next command clears err.
- XSUM (macro defined): count=2 with beats 1..16 -> xsum=0x10 (XOR of 1..16); macro undefined -> xsum=0.

Source files
------------

// File: rtl/tensor_desc_loader_pkg.sv
// Shared types and constants for the tensor descriptor loader.
// The optional beat checksum is enabled by defining DESC_LOADER_XSUM_EN.
package tensor_desc_loader_pkg;

    // Loader FSM states, also exported on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } loader_state_e;

    // Size of one 256-bit descriptor in memory.
    localparam int DESC_BYTES = 32;

endpackage

// File: rtl/tensor_desc_loader_if.sv
// Memory read port of the descriptor loader.
// Handshake: a request transfers on a cycle where mem_req_valid && mem_req_ready;
// the requester keeps mem_req_valid and mem_req_addr stable until that cycle.
// A response transfers on any cycle with mem_rsp_valid (no backpressure);
// mem_rsp_data and mem_rsp_err are meaningful only while mem_rsp_valid is high.
interface tensor_desc_loader_if #(
    parameter int MEM_AW    = 32,
    parameter int BEAT_BITS = 32
);
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [MEM_AW-1:0]    mem_req_addr;
    logic                 mem_rsp_valid;
    logic [BEAT_BITS-1:0] mem_rsp_data;
    logic                 mem_rsp_err;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
    );
endinterface

// File: rtl/tensor_desc_loader_packer.sv
// Beat packer: inserts read beats little-endian into a descriptor-wide
// register. data_next_o shows the register including the beat being pushed,
// so the final beat can be captured in the same cycle it arrives.
module tensor_desc_loader_packer #(
    parameter int ENTRY_BITS = 256,
    parameter int BEAT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [BEAT_BITS-1:0]  beat_i,
    output logic [ENTRY_BITS-1:0] data_next_o,
    output logic                  last_o
);
    localparam int BEATS = ENTRY_BITS / BEAT_BITS;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [ENTRY_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    assign last_o      = (idx_q == IDX_W'(BEATS - 1));
    assign data_next_o = data_d;

    // Next beat slot and register contents; clear discards any partial descriptor.
    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (clr_i) begin
            data_d = '0;
            idx_d  = '0;
        end else if (push_i) begin
            data_d[idx_q*BEAT_BITS +: BEAT_BITS] = beat_i;
            if (!last_o) idx_d = idx_q + IDX_W'(1);
        end
    end

    // Packer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: rtl/tensor_desc_loader.sv
// Tensor descriptor loader: fetches descriptors beat by beat from memory and
// writes each complete descriptor into the descriptor table.
// Define DESC_LOADER_XSUM_EN to build the XOR checksum of accepted beats.
module tensor_desc_loader
    import tensor_desc_loader_pkg::*;
#(
    parameter int NUM_ENTRIES = 256,
    parameter int ENTRY_BITS  = 256,
    parameter int ADDR_W      = $clog2(NUM_ENTRIES),
    parameter int MEM_AW      = 32,
    parameter int BEAT_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MEM_AW-1:0]     cmd_mem_base,
    input  logic [ADDR_W-1:0]     cmd_tbl_base,
    input  logic [ADDR_W:0]       cmd_count,
    tensor_desc_loader_if.master  mem,
    output logic                  tbl_wr_en,
    output logic [ADDR_W-1:0]     tbl_wr_addr,
    output logic [ENTRY_BITS-1:0] tbl_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BEAT_BITS-1:0]  xsum,
    output loader_state_e         dbg_state
);
    localparam int BEAT_BYTES = BEAT_BITS / 8;

    loader_state_e         state_q, state_d;
    logic [MEM_AW-1:0]     cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]     cur_idx_q, cur_idx_d;
    logic [ADDR_W:0]       remaining_q, remaining_d;
    logic                  err_q, err_d;
    logic [ENTRY_BITS-1:0] wr_data_q, wr_data_d;

    logic                  pk_clr, pk_push, pk_last;
    logic [ENTRY_BITS-1:0] pk_data_next;

    tensor_desc_loader_packer #(
        .ENTRY_BITS (ENTRY_BITS),
        .BEAT_BITS  (BEAT_BITS)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (pk_clr),
        .push_i      (pk_push),
        .beat_i      (mem.mem_rsp_data),
        .data_next_o (pk_data_next),
        .last_o      (pk_last)
    );

    // Next-state, counters and packer control for the load sequence.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_idx_d   = cur_idx_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        wr_data_d   = wr_data_q;
        pk_clr      = 1'b0;
        pk_push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_mem_base;
                    cur_idx_d   = cmd_tbl_base;
                    remaining_d = cmd_count;
                    err_d       = 1'b0;
                    pk_clr      = 1'b1;
                    state_d     = (cmd_count == '0) ? ST_FINISH : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.mem_req_ready) begin
                    cur_addr_d = cur_addr_q + MEM_AW'(BEAT_BYTES);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    if (mem.mem_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        pk_push = 1'b1;
                        if (pk_last) begin
                            wr_data_d = pk_data_next;
                            state_d   = ST_WRITE;
                        end else begin
                            state_d   = ST_REQ;
                        end
                    end
                end
            end
            ST_WRITE: begin
                cur_idx_d   = (cur_idx_q == ADDR_W'(NUM_ENTRIES - 1)) ? '0
                                                                      : cur_idx_q + ADDR_W'(1);
                remaining_d = remaining_q - (ADDR_W + 1)'(1);
                pk_clr      = 1'b1;
                state_d     = (remaining_q == (ADDR_W + 1)'(1)) ? ST_FINISH : ST_REQ;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM, address/index counters and write-data holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            cur_idx_q   <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cur_idx_q   <= cur_idx_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            wr_data_q   <= wr_data_d;
        end
    end

`ifdef DESC_LOADER_XSUM_EN
    logic                 cmd_accept, beat_ok;
    logic [BEAT_BITS-1:0] xsum_q;
    assign cmd_accept = (state_q == ST_IDLE) && cmd_valid;
    assign beat_ok    = (state_q == ST_WAIT) && mem.mem_rsp_valid && !mem.mem_rsp_err;

    // Running XOR of good beats, restarted by each accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          xsum_q <= '0;
        else if (cmd_accept) xsum_q <= '0;
        else if (beat_ok)    xsum_q <= xsum_q ^ mem.mem_rsp_data;
    end
    assign xsum = xsum_q;
`else
    assign xsum = '0;
`endif

    assign cmd_ready         = (state_q == ST_IDLE);
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_FINISH);
    assign err               = err_q;
    assign mem.mem_req_valid = (state_q == ST_REQ);
    assign mem.mem_req_addr  = cur_addr_q;
    assign tbl_wr_en         = (state_q == ST_WRITE);
    assign tbl_wr_addr       = cur_idx_q;
    assign tbl_wr_data       = wr_data_q;
    assign dbg_state         = state_q;
endmodule
